// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and defaults for divided-clock monitors
package clk_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    LOCKED,
    ERROR
  } mon_state_t;

  localparam int CNT_W_DEFAULT    = 8;
  localparam int LOCK_CNT_DEFAULT = 4;

endpackage

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - sampling flops on an asynchronous level plus rising-edge detect
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_q[0] <= din;
      s_d       <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures period/high time of a divided clock and
// reports lock or sticky error against an expected even ratio
module div_clk_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int LOCK_CNT    = LOCK_CNT_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] ratio_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic             s;
  logic             rise;
  logic [CNT_W:0]   cnt;
  logic [CNT_W:0]   hcnt;
  logic [CNT_W:0]   limit;
  logic [CNT_W-1:0] ratio_q;
  logic [GW-1:0]    good_cnt;
  logic             timeout;
  logic             match;
  logic             lock_hit;
  logic             measuring;

  function automatic logic [CNT_W-1:0] clip(input logic [CNT_W:0] v);
    return v[CNT_W] ? '1 : v[CNT_W-1:0];
  endfunction

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (div_in),
    .s      (s),
    .rise   (rise)
  );

  // Counters are one bit wider than the ratio so 2*ratio never wraps.
  assign limit     = {ratio_q, 1'b0};
  assign timeout   = cnt > limit;
  assign match     = (cnt == {1'b0, ratio_q}) && (hcnt == {2'b00, ratio_q[CNT_W-1:1]});
  assign measuring = (state == MEASURE) || (state == LOCKED);
  assign lock_hit  = (good_cnt == GW'(LOCK_CNT - 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A rise always takes priority over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM: begin
          if (ratio_q < CNT_W'(2)) state_nxt = ERROR;
          else if (rise)           state_nxt = MEASURE;
          else if (timeout)        state_nxt = ERROR;
        end
        MEASURE: begin
          if (rise) begin
            if (match && lock_hit) state_nxt = LOCKED;
          end else if (timeout) begin
            state_nxt = ERROR;
          end
        end
        LOCKED: begin
          if (rise) begin
            if (!match) state_nxt = ERROR;
          end else if (timeout) begin
            state_nxt = ERROR;
          end
        end
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    locked = 1'b0;
    err    = 1'b0;
    case (state)
      LOCKED:  locked = 1'b1;
      ERROR:   err    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ratio_q    <= '0;
      cnt        <= '0;
      hcnt       <= '0;
      good_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
    end else if (!enable || state == IDLE) begin
      if (enable) ratio_q <= ratio_in;
      cnt        <= '0;
      hcnt       <= '0;
      good_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise) begin
        cnt  <= (CNT_W+1)'(1);
        hcnt <= (CNT_W+1)'(1);
        if (measuring) begin
          period_out <= clip(cnt);
          high_out   <= clip(hcnt);
          meas_valid <= 1'b1;
          if (state == MEASURE) good_cnt <= match ? good_cnt + 1'b1 : '0;
        end
      end else begin
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (s && hcnt != '1) hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Single-clock checker for divided clocks generated from `clk_in`: samples a divided-clock signal, measures rise-to-rise period and high time in `clk_in` cycles, and compares both against an expected even divide ratio. It sits beside the clock-divider outputs, for example /2, /4 and /8, and reports `locked` or `err` to status logic. One instance is used per monitored divided clock.

## Interface
- `CNT_W`, 8: width of the ratio and measurement fields.
- `LOCK_CNT`, 4: consecutive matching periods required to assert `locked`.
- `SYNC_STAGES`, 2: sampling flops on `div_in`. Minimum 1.
- `clk_in`  in  1  system clock; only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `div_in`  in  1  divided clock under test, sampled as data.
- `enable`  in  1  1 = run monitor; 0 = return to IDLE and clear status.
- `ratio_in`  in  CNT_W  expected period in `clk_in` cycles. Even, ≥2. Captured on IDLE→ARM.
- `period_out`  out  CNT_W  last measured rise-to-rise period. Saturates at all-ones.
- `high_out`  out  CNT_W  cycles the sampled `div_in` was high in that period. Saturates.
- `meas_valid`  out  1  one-cycle pulse when `period_out` and `high_out` update.
- `locked`  out  1  `LOCK_CNT` consecutive matching periods seen.
- `err`  out  1  sticky fault. Cleared only by `enable`=0 or reset.

## Operation
- Sampling: `div_in` → SYNC_STAGES flops → `s`. Previous-sample register `s_d`. `rise = s & ~s_d`.
- Counters, internal width CNT_W+1:
  - `cnt`: loads 1 on `rise`, otherwise increments, saturating.
  - `hcnt`: loads 1 on `rise`, otherwise increments when `s`=1, saturating.
- On `rise` in MEASURE or LOCKED, register the pre-load values into `period_out` and `high_out` (clipped to CNT_W) and pulse `meas_valid`.
- Match condition: `period == ratio_q` and `high == ratio_q/2`. Exact match only; no tolerance.
- Timeout condition: `cnt > 2*ratio_q`, computed in CNT_W+1 bits.
- States:
  - IDLE: counters, `good_cnt` and all outputs are 0. `enable`=1 → ARM, capturing `ratio_in` into `ratio_q`.
  - ARM: waits for the first `rise`, which produces no measurement and goes to MEASURE. `ratio_q`<2 → ERROR on the first ARM cycle. Timeout → ERROR.
  - MEASURE: each rise with a match increments `good_cnt`; a mismatch clears `good_cnt` with no error. When `good_cnt` reaches LOCK_CNT → LOCKED. Timeout → ERROR.
  - LOCKED: a mismatch or timeout → ERROR.
  - ERROR: `err`=1 and `locked`=0. Holds until `enable`=0.
- `enable`=0 in any state → IDLE on the next edge. This clears `err`, `locked` and all counters.
- Changes to `ratio_in` while enabled are ignored.

## Timing
- Reset: state IDLE. `period_out`, `high_out`, `meas_valid`, `locked` and `err` are all 0.
- Latency: a `div_in` rising edge at cycle t gives `rise` at t+SYNC_STAGES. `meas_valid` and the new values appear at t+SYNC_STAGES+1.
- `locked` rises in the same cycle as the `meas_valid` of the LOCK_CNT-th consecutive match.
- `err` rises and `locked` falls in the same cycle as the offending `meas_valid`. For a timeout, they rise/fall one cycle after `cnt` exceeds 2*ratio_q.
- Ratio 2 (`div_in` toggles every cycle) is supported: `rise` every 2 cycles, period 2, high 1.
- Reset while LOCKED or ERROR: outputs clear immediately (asynchronous), then operation restarts from IDLE.
- `rise` and timeout in the same cycle: `rise` wins, and the count is evaluated as a period mismatch.

## Structure
- Shared package `clk_div_pkg`:
  - state typedef `mon_state_t` with values IDLE, ARM, MEASURE, LOCKED, ERROR;
  - default constants for CNT_W and LOCK_CNT.
- Sub-module `sync_rise_det`: SYNC_STAGES sampling flops plus the edge register. Outputs `s` and `rise`. Reused by the other clock monitors.
- The top holds the counters, compare logic and FSM.

## Test plan
- ratio_in=4, `div_in` = 50% /4 of `clk_in`, then `enable`=1 → `meas_valid` every 4 cycles with `period_out`=4 and `high_out`=2. `locked`=1 on the 4th pulse; `err` stays 0.
- ratio_in=2, /2 clock → `period_out`=2, `high_out`=1, `locked` after 4 pulses.
- ratio_in=8, /4 clock → `period_out`=4 each pulse, `locked` never asserts, `err` stays 0.
- ratio_in=8 and locked, then hold `div_in`=0 → `err`=1 and `locked`=0 one cycle after `cnt` reaches 17. Then `enable`=0 for 1 cycle → `err`=0.
- ratio_in=4 and locked, stretch one period to 6 cycles (high 3) → `meas_valid` with `period_out`=6 and `high_out`=3, with `err`=1 and `locked`=0 in the same cycle.
- `rst_n` low mid-LOCKED → all outputs 0 asynchronously. After release with `enable` held 1 → ARM, and re-lock after 1+4 edges.
